// File: rtl/inst_fetch_if.sv
// ----------------------------------------------------------------------------
// inst_fetch_if
//   Bundles every non-clock/reset signal of the fetch stage:
//     PC side     : pc (in), pc_advance (out), flush (in)
//     IMEM side   : imem_req/imem_addr (out), imem_ack/imem_rdata (in)
//     Decode side : instr_valid/instr/instr_pc (out), instr_ready (in)
//     Status      : misalign_err (out, sticky)
//   master : view of the fetch stage itself
//   slave  : view of the surrounding PC / memory / decode logic
// ----------------------------------------------------------------------------
interface inst_fetch_if;
    logic [31:0] pc;
    logic        pc_advance;
    logic        flush;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    logic        misalign_err;

    modport master (
        input  pc, flush, imem_ack, imem_rdata, instr_ready,
        output pc_advance, imem_req, imem_addr,
               instr_valid, instr, instr_pc, misalign_err
    );

    modport slave (
        output pc, flush, imem_ack, imem_rdata, instr_ready,
        input  pc_advance, imem_req, imem_addr,
               instr_valid, instr, instr_pc, misalign_err
    );
endinterface

// File: rtl/inst_fetch.sv
// ----------------------------------------------------------------------------
// inst_fetch
//   Fetch stage sitting directly behind the PC register. Issues one
//   instruction-memory read at a time (req/ack, variable latency), buffers
//   returned words with their fetch address in a DEPTH-entry FIFO towards
//   decode (valid/ready), strobes pc_advance once per accepted word and
//   supports a flush that discards buffered and in-flight fetches.
//
//   Ports:
//     clock : rising-edge clock
//     reset : asynchronous, active-low reset
//     bus   : inst_fetch_if.master (PC, IMEM and decode handshakes)
//
//   Parameters:
//     DEPTH : FIFO entries, 2 or 4
//     PTR_W : log2(DEPTH)
// ----------------------------------------------------------------------------
module inst_fetch #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic          clock,
    input  logic          reset,
    inst_fetch_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ADV   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    state_t            state_q, state_d;
    logic [31:0]       req_pc_q, req_pc_d;
    logic              imem_req_q, imem_req_d;
    logic              misalign_q, misalign_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [31:0]       fifo_instr_q [DEPTH];
    logic [31:0]       fifo_instr_d [DEPTH];
    logic [31:0]       fifo_pc_q    [DEPTH];
    logic [31:0]       fifo_pc_d    [DEPTH];

    logic              push;
    logic              pop;
    logic              pc_advance;
    logic              head_valid;

    assign head_valid = (count_q != '0);

    // ------------------------------------------------------------------
    // Fetch control: next state, request register, misalign flag
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        imem_req_d = imem_req_q;
        misalign_d = misalign_q;
        push       = 1'b0;
        pc_advance = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!bus.flush) begin
                    if (bus.pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end else if (count_q < CNT_FULL) begin
                        req_pc_d   = bus.pc;
                        imem_req_d = 1'b1;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.imem_ack) begin
                    imem_req_d = 1'b0;
                    push       = ~bus.flush;
                    state_d    = bus.flush ? IDLE : ADV;
                end else if (bus.flush) begin
                    // The read already left; wait for its ack and drop it.
                    state_d = DRAIN;
                end
            end
            ADV: begin
                pc_advance = ~bus.flush;
                state_d    = IDLE;
            end
            DRAIN: begin
                if (bus.imem_ack) begin
                    imem_req_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction FIFO
    // ------------------------------------------------------------------
    assign pop = head_valid & bus.instr_ready & ~bus.flush;

    always_comb begin
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;

        if (bus.flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                fifo_instr_d[wr_ptr_q] = bus.imem_rdata;
                fifo_pc_d[wr_ptr_q]    = req_pc_q;
                wr_ptr_d               = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_pc_q     <= '0;
            imem_req_q   <= 1'b0;
            misalign_q   <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_instr_q <= '{default: '0};
            fifo_pc_q    <= '{default: '0};
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            imem_req_q   <= imem_req_d;
            misalign_q   <= misalign_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_pc_q    <= fifo_pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs; the head is masked so an empty FIFO always reads as zero.
    // ------------------------------------------------------------------
    assign bus.imem_req     = imem_req_q;
    assign bus.imem_addr    = req_pc_q;
    assign bus.pc_advance   = pc_advance;
    assign bus.instr_valid  = head_valid;
    assign bus.instr        = head_valid ? fifo_instr_q[rd_ptr_q] : '0;
    assign bus.instr_pc     = head_valid ? fifo_pc_q[rd_ptr_q]    : '0;
    assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_inst_fetch.sv
// ----------------------------------------------------------------------------
// tb_inst_fetch
//   Bench for inst_fetch (DEPTH=2). The bench plays PC register, instruction
//   memory and decode. A queue of {pc, word} models the decode-facing FIFO and
//   is checked against the DUT once per cycle on the falling edge; directed
//   scenarios add literal expectations.
// ----------------------------------------------------------------------------
module tb_inst_fetch;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    inst_fetch_if bus ();

    inst_fetch #(.DEPTH(2), .PTR_W(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    entry_t      exp_q[$];
    logic [31:0] pop_log[$];
    bit          live = 0;
    logic [31:0] live_addr = '0;
    bit          adv_exp = 0;

    int          lat = 1;
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    bit          force_ack = 0;
    bit          ready_on_ack = 0;

    logic [31:0] last_req_addr = '0;
    int          req_seen = 0;
    int          req_start_cyc = 0;
    int          adv_pulses = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        case (a)
            32'h0040_0000: return 32'h2008_0005;
            32'h0000_0000: return 32'h0000_000A;
            32'h0000_0004: return 32'h0000_000B;
            32'h0000_0008: return 32'h0000_000C;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: memory response, per-cycle compare, model update.
    task automatic step();
        logic        adv_seen;
        logic [31:0] pc_prev;
        entry_t      e;

        if (!reset) begin
            mem_busy = 0;
            live     = 0;
            adv_exp  = 0;
            exp_q.delete();
        end

        if (force_ack) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = 32'hBAD0_BAD0;
            force_ack      = 0;
        end else if (mem_busy && mem_cnt == 0) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = word_of(mem_addr);
        end else begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = '0;
            if (mem_busy) mem_cnt--;
        end
        if (ready_on_ack) bus.instr_ready = bus.imem_ack;

        @(negedge clock);
        check1("instr_valid", bus.instr_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("instr", bus.instr, exp_q[0].word);
            check("instr_pc", bus.instr_pc, exp_q[0].pc);
        end
        check1("pc_advance", bus.pc_advance, adv_exp && !bus.flush);
        if (bus.imem_req && mem_busy) check("imem_addr_hold", bus.imem_addr, mem_addr);
        adv_seen = bus.pc_advance;
        if (adv_seen) adv_pulses++;

        adv_exp = 0;
        if (!reset || bus.flush) begin
            exp_q.delete();
            live = 0;
        end else begin
            if (exp_q.size() != 0 && bus.instr_ready) begin
                e = exp_q.pop_front();
                pop_log.push_back(e.word);
            end
            if (bus.imem_ack && live) begin
                e.pc   = live_addr;
                e.word = bus.imem_rdata;
                exp_q.push_back(e);
                live    = 0;
                adv_exp = 1;
            end
        end
        pc_prev = bus.pc;

        @(posedge clock);
        #1;
        cyc++;
        if (bus.imem_ack) mem_busy = 0;
        if (adv_seen) bus.pc = bus.pc + 32'd4;
        if (!reset) mem_busy = 0;
        if (reset && bus.imem_req && !mem_busy) begin
            mem_busy      = 1;
            mem_cnt       = lat;
            mem_addr      = bus.imem_addr;
            live          = 1;
            live_addr     = pc_prev;
            last_req_addr = bus.imem_addr;
            req_seen++;
            req_start_cyc = cyc;
            check("issue_addr", bus.imem_addr, pc_prev);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rs;
        int ap;

        bus.pc          = 32'h0040_0000;
        bus.flush       = 1'b0;
        bus.instr_ready = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;

        // Reset values, no clock edge yet
        #1;
        check1("rst_imem_req", bus.imem_req, 1'b0);
        check("rst_imem_addr", bus.imem_addr, 32'h0);
        check1("rst_pc_advance", bus.pc_advance, 1'b0);
        check1("rst_instr_valid", bus.instr_valid, 1'b0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_instr_pc", bus.instr_pc, 32'h0);
        check1("rst_misalign", bus.misalign_err, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Basic fetch
        lat = 1;
        for (int i = 0; i < 10 && req_seen < 1; i++) step();
        check("basic_first_addr", last_req_addr, 32'h0040_0000);
        for (int i = 0; i < 10 && !bus.instr_valid; i++) step();
        check1("basic_valid", bus.instr_valid, 1'b1);
        check("basic_latency", 32'(cyc - req_start_cyc), 32'd2);
        check("basic_instr", bus.instr, 32'h2008_0005);
        check("basic_instr_pc", bus.instr_pc, 32'h0040_0000);
        step();
        step();
        check("basic_adv_pulses", 32'(adv_pulses), 32'd1);

        // Backpressure
        bus.pc = 32'h0;
        bus.instr_ready = 1'b0;
        lat = 1;
        do_reset();
        pop_log.delete();
        for (int i = 0; i < 30 && exp_q.size() < 2; i++) step();
        rs = req_seen;
        for (int i = 0; i < 6; i++) step();
        check("bp_no_new_req", 32'(req_seen - rs), 32'd0);
        check1("bp_imem_req_low", bus.imem_req, 1'b0);
        check1("bp_valid", bus.instr_valid, 1'b1);
        check("bp_head", bus.instr, 32'h0000_000A);
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 10 && req_seen == rs; i++) step();
        check("bp_resume_addr", last_req_addr, 32'h0000_0008);
        for (int i = 0; i < 10 && pop_log.size() < 2; i++) step();
        check("bp_pop0", pop_log.size() > 0 ? pop_log[0] : 32'hX, 32'h0000_000A);
        check("bp_pop1", pop_log.size() > 1 ? pop_log[1] : 32'hX, 32'h0000_000B);

        // Flush while a request is outstanding
        bus.pc = 32'h0040_0000;
        bus.instr_ready = 1'b1;
        lat = 4;
        do_reset();
        rs = req_seen;
        for (int i = 0; i < 10 && req_seen == rs; i++) step();
        ap = adv_pulses;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.pc = 32'h0040_0100;
        rs = req_seen;
        for (int i = 0; i < 10 && mem_busy; i++) begin
            check1("drain_req_held", bus.imem_req, 1'b1);
            step();
        end
        check1("drain_ack_seen", mem_busy, 1'b0);
        check1("drain_no_valid", bus.instr_valid, 1'b0);
        for (int i = 0; i < 10 && req_seen == rs; i++) step();
        check("flush_new_addr", last_req_addr, 32'h0040_0100);
        check("flush_no_adv", 32'(adv_pulses - ap), 32'd0);

        // Misaligned PC
        bus.pc = 32'h0040_0002;
        lat = 1;
        do_reset();
        rs = req_seen;
        for (int i = 0; i < 5; i++) step();
        check("mis_no_req", 32'(req_seen - rs), 32'd0);
        check1("mis_imem_req", bus.imem_req, 1'b0);
        check1("mis_err_set", bus.misalign_err, 1'b1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        step();
        step();
        check1("mis_err_after_flush", bus.misalign_err, 1'b1);
        reset = 1'b0;
        #1;
        check1("mis_err_reset", bus.misalign_err, 1'b0);

        // Push and pop on the same edge
        bus.pc = 32'h0000_1000;
        bus.instr_ready = 1'b0;
        lat = 2;
        do_reset();
        pop_log.delete();
        for (int i = 0; i < 20 && exp_q.size() < 1; i++) step();
        ready_on_ack = 1;
        for (int i = 0; i < 20 && pop_log.size() < 1; i++) step();
        ready_on_ack = 0;
        bus.instr_ready = 1'b0;
        check("pp_popped", pop_log.size() > 0 ? pop_log[0] : 32'hX, 32'h5A5A_1000);
        check1("pp_valid", bus.instr_valid, 1'b1);
        check("pp_instr", bus.instr, 32'h5A5A_1004);
        check("pp_instr_pc", bus.instr_pc, 32'h0000_1004);
        check("pp_model_count", 32'(exp_q.size()), 32'd1);

        // Asynchronous reset in the middle of a request
        bus.pc = 32'h0000_2000;
        bus.instr_ready = 1'b0;
        lat = 1;
        do_reset();
        for (int i = 0; i < 20 && exp_q.size() < 1; i++) step();
        lat = 5;
        rs = req_seen;
        for (int i = 0; i < 10 && req_seen == rs; i++) step();
        step();
        check1("ar_pre_req", bus.imem_req, 1'b1);
        check1("ar_pre_valid", bus.instr_valid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check1("ar_req_cleared", bus.imem_req, 1'b0);
        check1("ar_valid_cleared", bus.instr_valid, 1'b0);
        check1("ar_adv_cleared", bus.pc_advance, 1'b0);
        check("ar_addr_cleared", bus.imem_addr, 32'h0);
        step();
        reset = 1'b1;
        lat = 1;
        force_ack = 1;
        step();
        step();
        check1("ar_late_ack_ignored", bus.instr_valid, 1'b0);
        for (int i = 0; i < 4; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
